// File: rtl/pong_pkg.sv
// Shared constants for the match datapath: FSM encoding, default timing and
// the ball-period calculation used by the top level.
package pong_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_WON   = 2'd3;

  localparam int unsigned DEF_LEVEL_CYCLES = 32'd2_000_000_000;
  localparam int unsigned DEF_SERVE_CYCLES = 32'd500_000_000;
  localparam int unsigned DEF_BASE_DIV     = 32'd2_000_000;
  localparam int unsigned DEF_DIV_STEP     = 32'd100_000;
  localparam int unsigned DEF_MIN_DIV      = 32'd200_000;

  localparam int DIV_W = 32;

  // Wide signed intermediate so a large k pushes the period below the floor
  // instead of wrapping around.
  function automatic logic [DIV_W-1:0] calc_period(input int unsigned k,
                                                   input int unsigned base,
                                                   input int unsigned step,
                                                   input int unsigned min_div);
    longint p;
    p = longint'(base) - longint'(k) * longint'(step);
    if (p < longint'(min_div)) p = longint'(min_div);
    return p[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/pong_tick_div.sv
// Programmable ball-tick divider: one-cycle tick every `period` enabled cycles,
// with the period sampled only at a wrap so changes never shorten a count.
module pong_tick_div
  import pong_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    tick_d = 1'b0;
    if (!en) begin
      cnt_d = '0;
      per_d = period;
    end else if (cnt_q == per_q - DIV_W'(1)) begin
      cnt_d  = '0;
      per_d  = period;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q  <= '0;
      per_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pong_match_datapath.sv
// Match datapath: serve/play/won FSM, N-player versus scores, practice hits and
// levels, and the ball-tick divider feeding the motion logic.
module pong_match_datapath
  import pong_pkg::*;
#(
  parameter int          NUM_PLAYERS  = 2,
  parameter int          SW           = 4,
  parameter int          WIN_SCORE    = 5,
  parameter int          NUM_LEVELS   = 10,
  parameter int unsigned LEVEL_CYCLES = DEF_LEVEL_CYCLES,
  parameter int unsigned SERVE_CYCLES = DEF_SERVE_CYCLES,
  parameter int unsigned BASE_DIV     = DEF_BASE_DIV,
  parameter int unsigned DIV_STEP     = DEF_DIV_STEP,
  parameter int unsigned MIN_DIV      = DEF_MIN_DIV,
  localparam int         PW           = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int         LW           = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      mode,
  input  logic [1:0]                speed_sel,
  input  logic                      round_start,
  input  logic                      hit,
  input  logic                      point_valid,
  input  logic [PW-1:0]             point_player,
  input  logic                      clear_all,
  output logic                      ball_tick,
  output logic                      serve_pause,
  output logic [LW-1:0]             level,
  output logic [SW-1:0]             hit_count,
  output logic [NUM_PLAYERS*SW-1:0] scores,
  output logic                      winner_valid,
  output logic [PW-1:0]             winner_id
);

  logic [1:0]             state_q, state_d;
  logic                   mode_q, mode_d;
  logic [31:0]            serve_tmr_q, serve_tmr_d;
  logic [31:0]            lvl_tmr_q, lvl_tmr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [SW-1:0]          hit_q, hit_d;
  logic                   win_q, win_d;
  logic [PW-1:0]          win_id_q, win_id_d;
  logic [NUM_PLAYERS-1:0] win_hit;
  logic                   pt_ok, pt_wins, tick_raw;
  logic [DIV_W-1:0]       period;

  // Practice accepts any point; versus drops points for non-existent players.
  assign pt_ok   = point_valid && (state_q == ST_PLAY) &&
                   (!mode_q || (int'(point_player) < NUM_PLAYERS));
  assign pt_wins = |win_hit;

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score
    logic [SW-1:0] score_q, score_d;
    logic          inc;
    assign inc         = pt_ok && mode_q && (int'(point_player) == gi);
    assign win_hit[gi] = inc && (score_q == SW'(WIN_SCORE - 1));
    always_comb begin
      score_d = score_q;
      if (clear_all)                                 score_d = '0;
      else if (inc && (score_q != SW'(WIN_SCORE)))   score_d = score_q + SW'(1);
    end
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) score_q <= '0;
      else      score_q <= score_d;
    end
    assign scores[gi*SW +: SW] = score_q;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    serve_tmr_d = '0;
    lvl_tmr_d   = lvl_tmr_q;
    level_d     = level_q;
    hit_d       = hit_q;
    win_d       = win_q;
    win_id_d    = win_id_q;
    case (state_q)
      ST_IDLE: if (round_start) begin
        state_d = ST_SERVE;
        mode_d  = mode;
      end
      ST_SERVE: begin
        if (serve_tmr_q == SERVE_CYCLES - 1) state_d = ST_PLAY;
        else                                 serve_tmr_d = serve_tmr_q + 32'd1;
      end
      ST_PLAY: begin
        if (pt_ok) begin
          if (pt_wins) begin
            state_d  = ST_WON;
            win_d    = 1'b1;
            win_id_d = point_player;
          end else begin
            state_d = ST_SERVE;
          end
        end else if (hit && !mode_q && (hit_q != '1)) begin
          hit_d = hit_q + SW'(1);
        end
        if (!mode_q) begin
          if (lvl_tmr_q == LEVEL_CYCLES - 1) begin
            lvl_tmr_d = '0;
            if (level_q != LW'(NUM_LEVELS - 1)) level_d = level_q + LW'(1);
          end else begin
            lvl_tmr_d = lvl_tmr_q + 32'd1;
          end
        end
      end
      default: ;
    endcase
    if (clear_all) begin
      state_d     = ST_IDLE;
      mode_d      = 1'b0;
      serve_tmr_d = '0;
      lvl_tmr_d   = '0;
      level_d     = '0;
      hit_d       = '0;
      win_d       = 1'b0;
      win_id_d    = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      serve_tmr_q <= '0;
      lvl_tmr_q   <= '0;
      level_q     <= '0;
      hit_q       <= '0;
      win_q       <= 1'b0;
      win_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      serve_tmr_q <= serve_tmr_d;
      lvl_tmr_q   <= lvl_tmr_d;
      level_q     <= level_d;
      hit_q       <= hit_d;
      win_q       <= win_d;
      win_id_q    <= win_id_d;
    end
  end

  assign period = calc_period(mode_q ? 32'(speed_sel) : 32'(level_q),
                              BASE_DIV, DIV_STEP, MIN_DIV);

  pong_tick_div u_tick_div (
    .Clk    (Clk),
    .Rst    (Rst),
    .en     (state_q == ST_PLAY),
    .period (period),
    .tick   (tick_raw)
  );

  // A wrap landing on the PLAY exit edge must not leak a tick into SERVE/WON.
  assign ball_tick    = tick_raw & (state_q == ST_PLAY);
  assign serve_pause  = (state_q == ST_SERVE);
  assign level        = level_q;
  assign hit_count    = hit_q;
  assign winner_valid = win_q;
  assign winner_id    = win_id_q;

endmodule

// File: tb/tb_pong_match_datapath.sv
// Scenario bench for pong_match_datapath with small timing constants; expected
// values are queued when stimulus is driven and popped when the DUT responds.
module tb_pong_match_datapath;

  localparam int NP = 3;
  localparam int SW = 4;
  localparam int PW = 2;
  localparam int LW = 4;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic             mode = 1'b0;
  logic [1:0]       speed_sel = 2'd0;
  logic             round_start = 1'b0;
  logic             hit = 1'b0;
  logic             point_valid = 1'b0;
  logic [PW-1:0]    point_player = '0;
  logic             clear_all = 1'b0;
  logic             ball_tick, serve_pause, winner_valid;
  logic [LW-1:0]    level;
  logic [SW-1:0]    hit_count;
  logic [NP*SW-1:0] scores;
  logic [PW-1:0]    winner_id;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int tick_q[$];

  always #5 Clk = ~Clk;

  pong_match_datapath #(
    .NUM_PLAYERS(NP), .SW(SW), .WIN_SCORE(5), .NUM_LEVELS(10),
    .LEVEL_CYCLES(10), .SERVE_CYCLES(4), .BASE_DIV(16), .DIV_STEP(2), .MIN_DIV(4)
  ) dut (
    .Clk(Clk), .Rst(Rst), .mode(mode), .speed_sel(speed_sel),
    .round_start(round_start), .hit(hit), .point_valid(point_valid),
    .point_player(point_player), .clear_all(clear_all), .ball_tick(ball_tick),
    .serve_pause(serve_pause), .level(level), .hit_count(hit_count),
    .scores(scores), .winner_valid(winner_valid), .winner_id(winner_id)
  );

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic int score_of(input int p);
    return int'(scores[p*SW +: SW]);
  endfunction

  // Waits out a serve pause; the number of SERVE cycles seen is itself checked.
  task automatic to_play(input int exp_n);
    int n = 0;
    while (serve_pause === 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != exp_n || serve_pause !== 1'b0) begin
      errors++;
      $display("FAIL serve_len got %0d cycles (serve_pause=%b) required %0d", n, serve_pause, exp_n);
    end
  endtask

  task automatic start_round(input logic m);
    mode = m;
    round_start = 1'b1;
    step();
    round_start = 1'b0;
    to_play(4);
  endtask

  task automatic do_point(input int p);
    point_valid = 1'b1;
    point_player = PW'(p);
    step();
    point_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
  endtask

  task automatic test_reset();
    int pts[5] = '{0, 0, 0, 1, 1};
    int got, exp_v, ticks;
    Rst = 1'b0;
    repeat (2) step();
    checks++;
    if ({ball_tick, serve_pause, level, hit_count, scores, winner_valid, winner_id} !== '0) begin
      errors++;
      $display("FAIL reset_state got tick=%b sp=%b lvl=%0d hits=%0d scores=%h win=%b id=%0d required all 0",
               ball_tick, serve_pause, level, hit_count, scores, winner_valid, winner_id);
    end
    Rst = 1'b1;
    step();
    start_round(1'b1);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(score_of(pts[i]) + 1);
      do_point(pts[i]);
      got = score_of(pts[i]);
      exp_v = exp_q.pop_front();
      $display("txn reset_setup player %0d score %0d expected %0d", pts[i], got, exp_v);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL setup_score got %0d required %0d", got, exp_v);
      end
      to_play(4);
    end
    checks++;
    if (scores !== {4'd0, 4'd2, 4'd3}) begin
      errors++;
      $display("FAIL scores_3_2 got %h required %h", scores, {4'd0, 4'd2, 4'd3});
    end
    #2 Rst = 1'b0;
    #1;
    checks++;
    if ({ball_tick, serve_pause, level, hit_count, scores, winner_valid, winner_id} !== '0) begin
      errors++;
      $display("FAIL async_reset got sp=%b scores=%h win=%b required all 0", serve_pause, scores, winner_valid);
    end
    #2 Rst = 1'b1;
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ball_tick === 1'b1 || serve_pause === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 0) begin
      errors++;
      $display("FAIL reset_idle got %0d active cycles required 0", ticks);
    end
  endtask

  task automatic test_versus_win();
    int got, exp_v, ticks;
    start_round(1'b1);
    for (int n = 1; n <= 5; n++) begin
      exp_q.push_back(n);
      do_point(1);
      got = score_of(1);
      exp_v = exp_q.pop_front();
      $display("txn versus point %0d score %0d expected %0d", n, got, exp_v);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL versus_score got %0d required %0d", got, exp_v);
      end
      if (n < 5) to_play(4);
    end
    checks++;
    if (winner_valid !== 1'b1 || winner_id !== 2'd1 || serve_pause !== 1'b0) begin
      errors++;
      $display("FAIL winner got valid=%b id=%0d sp=%b required 1 1 0", winner_valid, winner_id, serve_pause);
    end
    do_point(1);
    do_point(0);
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ball_tick === 1'b1) ticks++;
    end
    checks++;
    if (scores !== {4'd0, 4'd5, 4'd0} || winner_valid !== 1'b1 || ticks != 0) begin
      errors++;
      $display("FAIL won_hold got scores=%h win=%b ticks=%0d required %h 1 0",
               scores, winner_valid, ticks, {4'd0, 4'd5, 4'd0});
    end
    do_clear();
    checks++;
    if (scores !== '0 || winner_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear got scores=%h win=%b required 0 0", scores, winner_valid);
    end
  endtask

  task automatic test_practice_level();
    int last = 0, prev = 0, exp_v;
    do_clear();
    start_round(1'b0);
    tick_q.push_back(16);
    tick_q.push_back(30);
    for (int rel = 1; rel <= 130; rel++) begin
      step();
      if (rel == 9 || rel == 10) begin
        checks++;
        if (int'(level) != rel / 10) begin
          errors++;
          $display("FAIL level_step at %0d got %0d required %0d", rel, level, rel / 10);
        end
      end
      if (ball_tick === 1'b1) begin
        prev = last;
        last = rel;
        if (rel <= 40) begin
          exp_v = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
          $display("txn practice tick at %0d expected %0d", rel, exp_v);
          checks++;
          if (rel != exp_v) begin
            errors++;
            $display("FAIL tick_time got %0d required %0d", rel, exp_v);
          end
        end
      end
      if (rel == 40) begin
        checks++;
        if (tick_q.size() != 0) begin
          errors++;
          $display("FAIL tick_missing got %0d pending required 0", tick_q.size());
          tick_q.delete();
        end
      end
    end
    checks++;
    if (level !== 4'd9 || (last - prev) != 4) begin
      errors++;
      $display("FAIL level_sat got level=%0d period=%0d required 9 4", level, last - prev);
    end
  endtask

  task automatic test_practice_hits();
    int exp_v;
    do_clear();
    start_round(1'b0);
    for (int n = 1; n <= 20; n++) begin
      exp_q.push_back(n > 15 ? 15 : n);
      hit = 1'b1;
      step();
      hit = 1'b0;
      exp_v = exp_q.pop_front();
      $display("txn hit %0d count %0d expected %0d", n, hit_count, exp_v);
      checks++;
      if (int'(hit_count) != exp_v) begin
        errors++;
        $display("FAIL hit_count got %0d required %0d", hit_count, exp_v);
      end
      if (n == 3) begin
        hit = 1'b1;
        point_valid = 1'b1;
        point_player = 2'd0;
        step();
        hit = 1'b0;
        point_valid = 1'b0;
        checks++;
        if (hit_count !== 4'd3 || serve_pause !== 1'b1 || scores !== '0) begin
          errors++;
          $display("FAIL hit_with_point got hits=%0d sp=%b scores=%h required 3 1 0",
                   hit_count, serve_pause, scores);
        end
        to_play(4);
      end
    end
  endtask

  task automatic test_versus_speed();
    int exp_v;
    do_clear();
    speed_sel = 2'd3;
    start_round(1'b1);
    for (int t = 1; t <= 4; t++) tick_q.push_back(10 * t);
    for (int rel = 1; rel <= 45; rel++) begin
      point_valid = (rel == 33);
      point_player = 2'd3;
      step();
      point_valid = 1'b0;
      if (rel == 33) begin
        checks++;
        if (scores !== '0 || serve_pause !== 1'b0) begin
          errors++;
          $display("FAIL bad_player got scores=%h sp=%b required 0 0", scores, serve_pause);
        end
      end
      if (ball_tick === 1'b1) begin
        exp_v = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
        $display("txn versus tick at %0d expected %0d", rel, exp_v);
        checks++;
        if (rel != exp_v) begin
          errors++;
          $display("FAIL speed_tick got %0d required %0d", rel, exp_v);
        end
      end
    end
    checks++;
    if (tick_q.size() != 0) begin
      errors++;
      $display("FAIL speed_missing got %0d pending required 0", tick_q.size());
      tick_q.delete();
    end
    speed_sel = 2'd0;
  endtask

  task automatic test_ignored();
    do_clear();
    mode = 1'b1;
    round_start = 1'b1;
    step();
    round_start = 1'b0;
    do_point(0);
    checks++;
    if (scores !== '0 || serve_pause !== 1'b1) begin
      errors++;
      $display("FAIL point_in_serve got scores=%h sp=%b required 0 1", scores, serve_pause);
    end
    to_play(3);
    round_start = 1'b1;
    step();
    round_start = 1'b0;
    checks++;
    if (serve_pause !== 1'b0) begin
      errors++;
      $display("FAIL start_in_play got sp=%b required 0", serve_pause);
    end
    mode = 1'b0;
    hit = 1'b1;
    step();
    hit = 1'b0;
    checks++;
    if (hit_count !== '0) begin
      errors++;
      $display("FAIL mode_toggle got hits=%0d required 0", hit_count);
    end
    exp_q.push_back(1);
    do_point(0);
    checks++;
    if (score_of(0) != exp_q[0] || serve_pause !== 1'b1) begin
      errors++;
      $display("FAIL versus_kept got score=%0d sp=%b required %0d 1", score_of(0), serve_pause, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_versus_win();
    test_practice_level();
    test_practice_hits();
    test_versus_speed();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
